// File: rtl/pwm_pkg.sv
// Shared types and defaults for the single-channel PWM generator.
// Used by pwm_generator and its optional dead-time stage.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } pwm_state_t;

    localparam int PWM_PERIOD_DEFAULT    = 16;
    localparam int PWM_DEAD_TIME_DEFAULT = 2;

endpackage

// File: rtl/pwm_dead_time_inserter.sv
// Delays each rising edge of i_in by DEAD_TIME clocks; falling edges pass after the
// usual single register stage. Used only when COMPLEMENTARY_OUT_EN is defined.
module dead_time_inserter
    import pwm_pkg::*;
#(
    parameter int DEAD_TIME = PWM_DEAD_TIME_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_in,
    output logic o_out
);

    localparam int            CW = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);
    localparam logic [CW-1:0] DT = CW'(DEAD_TIME);

    // r_run counts how many consecutive earlier cycles i_in has been high, saturating at DT
    logic [CW-1:0] r_run;
    logic          r_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run <= '0;
            r_out <= 1'b0;
        end else begin
            r_out <= i_in && (r_run >= DT);
            if (!i_in) begin
                r_run <= '0;
            end else if (r_run < DT) begin
                r_run <= r_run + CW'(1);
            end
        end
    end

    assign o_out = r_out;

endmodule

// File: rtl/pwm_generator.sv
// Single-channel PWM with double-buffered duty applied at period boundaries.
// Define COMPLEMENTARY_OUT_EN to add pwm_n_out with dead time on every rising edge.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int PERIOD    = PWM_PERIOD_DEFAULT,
    parameter int DEAD_TIME = PWM_DEAD_TIME_DEFAULT
) (
    input  logic                        clk_3125KHz,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [$clog2(PERIOD+1)-1:0] duty_in,
    input  logic                        duty_valid,
    output logic                        duty_ack,
    output logic                        period_start,
    output logic                        pwm_out
`ifdef COMPLEMENTARY_OUT_EN
    ,
    output logic                        pwm_n_out
`endif
);

    localparam int                CNT_W    = $clog2(PERIOD);
    localparam int                DUTY_W   = $clog2(PERIOD + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(PERIOD);

    if (PERIOD < 2 || DEAD_TIME < 0) begin : g_param_check
        $error("pwm_generator: PERIOD must be >= 2 and DEAD_TIME >= 0");
    end

    function automatic logic [DUTY_W-1:0] sat_duty(input logic [DUTY_W-1:0] d);
        return (d > DUTY_MAX) ? DUTY_MAX : d;
    endfunction

    pwm_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [DUTY_W-1:0] r_duty_active, r_pending;
    logic              r_pending_flag;
    logic              r_duty_ack;
    logic              r_period_start;

    logic              w_active;
    logic              w_last;
    logic              w_apply;
    logic              w_hi;
    logic [DUTY_W-1:0] w_duty_sat;

    assign w_active   = (r_state != IDLE);
    assign w_last     = (r_cnt == CNT_LAST);
    assign w_apply    = (w_active && w_last) || (r_state == IDLE && en);
    assign w_hi       = w_active && (DUTY_W'(r_cnt) < r_duty_active);
    assign w_duty_sat = sat_duty(duty_in);

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A stop seen on the last count of a period has nothing left to drain, so go straight to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_last ? '0 : r_cnt + CNT_W'(1);
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_nxt = w_last ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                if (en) begin
                    w_state_nxt = RUN;
                end else if (w_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // A strobe landing on the apply cycle bypasses the pending buffer.
    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_pending      <= '0;
            r_pending_flag <= 1'b0;
            r_duty_active  <= '0;
            r_duty_ack     <= 1'b0;
        end else begin
            r_duty_ack <= 1'b0;
            if (duty_valid) begin
                r_pending      <= w_duty_sat;
                r_pending_flag <= 1'b1;
            end
            if (w_apply && (duty_valid || r_pending_flag)) begin
                r_duty_active  <= duty_valid ? w_duty_sat : r_pending;
                r_pending_flag <= 1'b0;
                r_duty_ack     <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= w_active && (r_cnt == '0);
        end
    end

    assign duty_ack     = r_duty_ack;
    assign period_start = r_period_start;

`ifdef COMPLEMENTARY_OUT_EN
    logic w_lo;
    assign w_lo = w_active && !w_hi;

    dead_time_inserter #(
        .DEAD_TIME (DEAD_TIME)
    ) u_dt_pwm (
        .clk   (clk_3125KHz),
        .rst_n (rst_n),
        .i_in  (w_hi),
        .o_out (pwm_out)
    );

    dead_time_inserter #(
        .DEAD_TIME (DEAD_TIME)
    ) u_dt_pwm_n (
        .clk   (clk_3125KHz),
        .rst_n (rst_n),
        .i_in  (w_lo),
        .o_out (pwm_n_out)
    );
`else
    logic r_pwm;

    always_ff @(posedge clk_3125KHz or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm <= 1'b0;
        end else begin
            r_pwm <= w_hi;
        end
    end

    assign pwm_out = r_pwm;
`endif

endmodule

// File: tb/tb_pwm_generator.sv
// Scoreboard bench for pwm_generator (PERIOD=16, DEAD_TIME=2): stimulus queues the
// expected registered outputs per cycle; a negedge monitor pops and compares.
module tb_pwm_generator;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b0;
    logic       en         = 1'b0;
    logic       duty_valid = 1'b0;
    logic [4:0] duty_in    = '0;
    logic       duty_ack;
    logic       period_start;
    logic       pwm_out;
`ifdef COMPLEMENTARY_OUT_EN
    logic       pwm_n_out;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit g_mask_pwm = 1'b0;

    typedef struct {
        int   cyc;
        logic pwm;
        logic ps;
        logic ack;
        logic pwm_n;
        bit   chk_pwm;
        bit   chk_n;
    } exp_t;

    exp_t q[$];
    exp_t m_e;

    pwm_generator #(
        .PERIOD    (16),
        .DEAD_TIME (2)
    ) dut (
        .clk_3125KHz  (clk),
        .rst_n        (rst_n),
        .en           (en),
        .duty_in      (duty_in),
        .duty_valid   (duty_valid),
        .duty_ack     (duty_ack),
        .period_start (period_start),
        .pwm_out      (pwm_out)
`ifdef COMPLEMENTARY_OUT_EN
        ,
        .pwm_n_out    (pwm_n_out)
`endif
    );

    always #160 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, act, exp);
        end
    endtask

    // Monitor: the entry tagged with the current cycle describes what the outputs must show now.
    always @(negedge clk) begin
        if (q.size() != 0 && q[0].cyc == cyc) begin
            m_e = q.pop_front();
            check("period_start", period_start, m_e.ps);
            check("duty_ack", duty_ack, m_e.ack);
            if (m_e.chk_pwm) check("pwm_out", pwm_out, m_e.pwm);
`ifdef COMPLEMENTARY_OUT_EN
            if (m_e.chk_n) begin
                check("pwm_n_out", pwm_n_out, m_e.pwm_n);
                check("outputs_not_both_high", pwm_out & pwm_n_out, 1'b0);
            end
`endif
        end
    end

    task automatic push_exp(input logic xp, input logic xs, input logic xa,
                            input logic xn, input bit cp, input bit cn);
        exp_t x;
        x.cyc     = cyc + 1;
        x.pwm     = xp;
        x.ps      = xs;
        x.ack     = xa;
        x.pwm_n   = xn;
        x.chk_pwm = cp;
        x.chk_n   = cn;
        q.push_back(x);
    endtask

    // Drive one cycle of inputs; the expectation is for the outputs after the next edge.
    task automatic tick(input logic e, input logic dv, input logic [4:0] d,
                        input logic xp, input logic xs, input logic xa);
        en         = e;
        duty_valid = dv;
        duty_in    = d;
        push_exp(xp, xs, xa, 1'b0, !g_mask_pwm, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic tick_c(input logic e, input logic dv, input logic [4:0] d,
                          input logic xp, input logic xs, input logic xa, input logic xn);
        en         = e;
        duty_valid = dv;
        duty_in    = d;
        push_exp(xp, xs, xa, xn, 1'b1, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
`ifdef COMPLEMENTARY_OUT_EN
        g_mask_pwm = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_pwm_out", pwm_out, 1'b0);
        check("reset_period_start", period_start, 1'b0);
        check("reset_duty_ack", duty_ack, 1'b0);
        rst_n = 1'b1;

        // Basic run: capture 4 in IDLE, start, one ack, 4 high / 12 low
        tick(1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 16; k++) tick(1'b1, 1'b0, 5'd0, k < 4, k == 0, 1'b0);

        // Mid-period update: 3 then 10 strobed (last wins); current period stays 4
        for (int k = 0; k < 16; k++)
            tick(1'b1, k == 7 || k == 9, (k == 7) ? 5'd3 : 5'd10, k < 4, k == 0, k == 15);
        for (int k = 0; k < 16; k++) tick(1'b1, 1'b0, 5'd0, k < 10, k == 0, 1'b0);

        // Extremes: duty 0, then 20 strobed on the apply cycle (bypass) saturating to 16
        for (int k = 0; k < 16; k++) tick(1'b1, k == 2, 5'd0, k < 10, k == 0, k == 15);
        for (int k = 0; k < 16; k++) tick(1'b1, k == 15, 5'd20, 1'b0, k == 0, k == 15);
        for (int k = 0; k < 16; k++) tick(1'b1, k == 3, 5'd4, 1'b1, k == 0, k == 15);

        // Stop at counter 5: period completes, then IDLE outputs low
        for (int k = 0; k < 16; k++) tick(k < 5, 1'b0, 5'd0, k < 4, k == 0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        // Drop en at 3 and restore it at 12: no gap into the next period
        for (int k = 0; k < 16; k++) tick(!(k >= 3 && k < 12), 1'b0, 5'd0, k < 4, k == 0, 1'b0);
        for (int k = 0; k < 16; k++) tick(1'b1, k == 1, 5'd10, k < 4, k == 0, k == 15);

        // Async reset at counter 9 with pwm_out high, no clock edge needed
        for (int k = 0; k < 9; k++) tick(1'b1, 1'b0, 5'd0, k < 10, k == 0, 1'b0);
        @(negedge clk);
        #10;
        check("pre_reset_pwm_out", pwm_out, 1'b1);
        en         = 1'b0;
        duty_valid = 1'b0;
        rst_n      = 1'b0;
        #5;
        check("async_reset_pwm_out", pwm_out, 1'b0);
        check("async_reset_period_start", period_start, 1'b0);
        check("async_reset_duty_ack", duty_ack, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        // Back in IDLE with duty cleared: restart gives period_start only
        tick(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) tick(1'b1, 1'b0, 5'd0, 1'b0, k == 0, 1'b0);

`ifdef COMPLEMENTARY_OUT_EN
        // Duty 8 with 2-clock dead time: 6 high on each output, both-low gaps of 2
        for (int k = 0; k < 16; k++) tick(1'b1, k == 5, 5'd8, 1'b0, k == 0, k == 15);
        for (int p = 0; p < 2; p++)
            for (int k = 0; k < 16; k++)
                tick_c(1'b1, 1'b0, 5'd0, k >= 2 && k < 8, k == 0, 1'b0, k >= 10);
`endif

        @(negedge clk);
        #1;
        n_chk++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
